// File: rtl/lamp_button_driver.sv
// Lamp button driver: presses one of five toggle buttons until the
// selected lamp reaches the commanded state, or reports an error.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_idx, cmd_on   target lamp 0..4 and required final state
//   lamp              current lamp states from the toggle block
//   button            registered one-hot press pulses
//   busy              high when not IDLE
//   done, err         one-cycle result pulses in the first GAP cycle
module lamp_button_driver #(
  parameter int PRESS_CYCLES = 1,
  parameter int TIMEOUT      = 8,
  parameter int GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_idx,
  input  logic       cmd_on,
  input  logic [4:0] lamp,
  output logic [4:0] button,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    PRESS,
    WAIT_ACK,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       on_q, on_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [4:0] button_q, button_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  // Holds cmd_ready low until the first edge after reset release.
  logic       live_q;

  logic [7:0] lamp_ext;
  logic [7:0] sel_oh;
  logic       hit;

  // Zero-extended so illegal indices read a defined bit.
  assign lamp_ext = {3'b000, lamp};
  assign sel_oh   = 8'd1 << idx_q;
  assign hit      = (lamp_ext[idx_q] == on_q);

  assign cmd_ready = (state_q == IDLE) && live_q;
  assign busy      = (state_q != IDLE);
  assign button    = button_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    on_d     = on_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    button_d = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          idx_d   = cmd_idx;
          on_d    = cmd_on;
          state_d = CHECK;
        end
      end
      CHECK: begin
        cnt_d = '0;
        if (idx_q > 3'd4) begin
          err_d   = 1'b1;
          state_d = GAP;
        end else if (hit) begin
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          button_d = sel_oh[4:0];
          state_d  = PRESS;
        end
      end
      PRESS: begin
        if (cnt_q == 4'(PRESS_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          button_d = sel_oh[4:0];
        end
      end
      WAIT_ACK: begin
        // A match wins over a coincident timeout.
        if (hit) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end else if (tmr_q == 8'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = GAP;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      on_q     <= 1'b0;
      cnt_q    <= '0;
      tmr_q    <= '0;
      button_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      on_q     <= on_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      button_q <= button_d;
      done_q   <= done_d;
      err_q    <= err_d;
      live_q   <= 1'b1;
    end
  end

endmodule
